fp_to_int_seq: RTL and testbench
================================

# fp_to_int_seq

Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter. It is the decode-direction counterpart to the adder's mask/align/ALU/normalize path: the adder packs results into float format, and this block unpacks a packed float into a two's-complement integer. Conversion truncates toward zero and saturates on overflow. The mantissa is shifted one bit per cycle under a small FSM, with valid/ready handshakes on both sides.

## Interface
- Parameters: none (widths fixed at 32-bit float in, 32-bit integer out).
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand; equals (state == IDLE).
- in_float  input  32  IEEE-754 single: sign [31], exponent [30:23], fraction [22:0].
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- result  output  32  signed integer result.
- invalid  output  1  NaN, infinity, or out-of-range input.
- inexact  output  1  nonzero fractional bits were discarded.

## Operation
- Accept occurs when in_valid and in_ready are both high at a clock edge. The operand is classified and registered, and the FSM moves to SHIFT.
- Let e = exponent - 127 and mag = {1, fraction} (24 bits, zero-extended to 32).
- Classification at accept:
  - exponent == 255 (NaN or infinity): forced result; count = 0.
    - NaN: 0x8000_0000, invalid = 1.
    - +inf: 0x7FFF_FFFF, invalid = 1.
    - -inf: 0x8000_0000, invalid = 1.
  - exponent == 0 (zero or denormal): result = 0; count = 0; inexact = 1 unless fraction == 0.
  - e < 0: result = 0; inexact = 1; count = 0.
  - e == 31 with sign = 1 and fraction = 0: result = 0x8000_0000 exact; invalid = 0.
  - Other e >= 31: saturate by sign; invalid = 1.
  - 23 <= e <= 30: left shift, count = e - 23 (0..7).
  - 0 <= e <= 22: right shift, count = 23 - e (1..23).
- SHIFT state, per cycle:
  - If count > 0: shift mag one bit in the chosen direction and decrement count.
  - On a right shift, OR the discarded bit into sticky inexact.
  - If count == 0: apply sign (result = sign ? -mag : mag), or the forced value for special cases. Then move to DONE.
- DONE state: out_valid = 1. result, invalid and inexact are stable. On out_ready, move to IDLE.
- States are IDLE, SHIFT, DONE. The block has no other states and is never re-entered without passing through IDLE.

## Timing
- Reset values: state = IDLE, result = 0, invalid = 0, inexact = 0, out_valid = 0. in_ready = 1 during and after reset.
- Latency: out_valid rises count + 1 edges after the accept edge.
  - Minimum is 1 edge (specials, e = 23).
  - Maximum is 24 edges (e = 0).
- One transaction is in flight at a time. in_ready = 0 from the accept edge until the edge on which the result is accepted.
- The earliest next accept is the cycle after the result is taken.
- in_valid asserted while in_ready = 0 is ignored. The operand is not captured; the source must hold it.
- Back-pressure: while out_ready = 0 in DONE, all outputs hold indefinitely.
- out_valid and in_ready are never both high.
- Reset asserted in any state aborts the operation immediately. No result is emitted, and the pending operand is discarded.

## Structure
- The shared package fp_pkg holds:
  - float_t (packed struct: sign, exp[7:0], frac[22:0]).
  - BIAS = 127, EXP_SPECIAL = 255.
  - INT_MAX = 32'h7FFF_FFFF, INT_MIN = 32'h8000_0000.
  - The state enum (IDLE, SHIFT, DONE).
- Sub-module fp_classify is purely combinational: float_t in; class (zero/denormal/normal/inf/NaN), unbiased exponent and shift direction/count out. It is reusable by the adder's mask stage.
- The top level holds the FSM, mag register, count register and sticky inexact.

## Test plan
- 0x40490FDB (3.14159) -> result 3, inexact 1, invalid 0; out_valid 23 edges after accept.
- 0xC2F60000 (-123.0) -> 0xFFFF_FF85, inexact 0; 18 edges. 0x4B800001 -> 16777218 (0x0100_0002), exact; 2 edges.
- 0x4F000000 (2^31) -> 0x7FFF_FFFF, invalid 1. 0xCF000000 -> 0x8000_0000, invalid 0. 0x7FC00000 (NaN) -> 0x8000_0000, invalid 1; 1 edge.
- 0x3F000000 (0.5) -> 0, inexact 1. 0x00000000 -> 0, inexact 0. 0x00000001 (denormal) -> 0, inexact 1.
- Hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready 0, a new in_valid is not captured. Then accept the result and check back-to-back operation.
- Assert reset mid-SHIFT (while converting 0x40490FDB) -> next cycle IDLE, out_valid 0, all outputs 0. A subsequent conversion is correct.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared float field layout, constants and state/class enums
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

  localparam logic [7:0]  BIAS        = 8'd127;
  localparam logic [7:0]  EXP_SPECIAL = 8'd255;
  localparam logic [31:0] INT_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational float classifier: class, unbiased exponent, shift plan
module fp_classify
  import fp_pkg::*;
(
  input  float_t           f,
  output fp_class_t        cls,
  output logic signed [8:0] exp_unb,
  output logic             shift_left,
  output logic [4:0]       shift_count
);

  always_comb begin
    exp_unb = $signed({1'b0, f.exp}) - $signed({1'b0, BIAS});

    if (f.exp == EXP_SPECIAL) begin
      cls = (|f.frac) ? CLS_NAN : CLS_INF;
    end else if (f.exp == 8'd0) begin
      cls = (|f.frac) ? CLS_DENORM : CLS_ZERO;
    end else begin
      cls = CLS_NORMAL;
    end

    // The binary point sits 23 bits above the mantissa LSB; shift toward it.
    shift_left  = (exp_unb >= 9'sd23);
    shift_count = shift_left ? 5'(exp_unb - 9'sd23) : 5'(9'sd23 - exp_unb);
  end

endmodule

// File: rtl/fp_to_int_seq.sv
// rtl/fp_to_int_seq.sv - bit-serial float32 to int32 converter, truncating and saturating
module fp_to_int_seq
  import fp_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_float,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        invalid,
  output logic        inexact
);

  state_t           state;
  float_t           op;
  fp_class_t        cls;
  logic signed [8:0] exp_unb;
  logic             cls_left;
  logic [4:0]       cls_count;

  logic [31:0] mag;
  logic [4:0]  count;
  logic        left;
  logic        sign;
  logic        forced;
  logic [31:0] forced_value;
  logic        forced_invalid;
  logic        sticky;

  logic        acc_forced;
  logic [31:0] acc_value;
  logic        acc_invalid;
  logic        acc_inexact;

  assign op = float_t'(in_float);

  fp_classify u_classify (
    .f           (op),
    .cls         (cls),
    .exp_unb     (exp_unb),
    .shift_left  (cls_left),
    .shift_count (cls_count)
  );

  // Everything that cannot go through the shifter gets its final value decided at accept.
  always_comb begin
    acc_forced  = 1'b1;
    acc_value   = 32'd0;
    acc_invalid = 1'b0;
    acc_inexact = 1'b0;
    case (cls)
      CLS_NAN: begin
        acc_value   = INT_MIN;
        acc_invalid = 1'b1;
      end
      CLS_INF: begin
        acc_value   = op.sign ? INT_MIN : INT_MAX;
        acc_invalid = 1'b1;
      end
      CLS_ZERO: begin
        acc_value = 32'd0;
      end
      CLS_DENORM: begin
        acc_inexact = 1'b1;
      end
      default: begin
        if (exp_unb < 9'sd0) begin
          acc_inexact = 1'b1;
        end else if (exp_unb >= 9'sd31) begin
          acc_value   = op.sign ? INT_MIN : INT_MAX;
          acc_invalid = !((exp_unb == 9'sd31) && op.sign && (op.frac == 23'd0));
        end else begin
          acc_forced = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mag            <= 32'd0;
      count          <= 5'd0;
      left           <= 1'b0;
      sign           <= 1'b0;
      forced         <= 1'b0;
      forced_value   <= 32'd0;
      forced_invalid <= 1'b0;
      sticky         <= 1'b0;
      result         <= 32'd0;
      invalid        <= 1'b0;
      inexact        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag            <= {8'd0, 1'b1, op.frac};
            count          <= acc_forced ? 5'd0 : cls_count;
            left           <= cls_left;
            sign           <= op.sign;
            forced         <= acc_forced;
            forced_value   <= acc_value;
            forced_invalid <= acc_invalid;
            sticky         <= acc_inexact;
            state          <= SHIFT;
          end
        end
        SHIFT: begin
          if (count != 5'd0) begin
            if (left) begin
              mag <= mag << 1;
            end else begin
              mag    <= mag >> 1;
              sticky <= sticky | mag[0];
            end
            count <= count - 5'd1;
          end else begin
            if (forced) begin
              result  <= forced_value;
              invalid <= forced_invalid;
            end else begin
              result  <= sign ? (32'd0 - mag) : mag;
              invalid <= 1'b0;
            end
            inexact <= sticky;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_to_int_seq.sv
// tb/tb_fp_to_int_seq.sv - randomized self-checking bench against a value-level conversion model
module tb_fp_to_int_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_float;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        invalid;
  logic        inexact;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_result  = 32'd0;
  logic        exp_invalid = 1'b0;
  logic        exp_inexact = 1'b0;
  logic        armed       = 1'b0;

  logic [31:0] vec_f   [11] = '{32'h40490FDB, 32'hC2F60000, 32'h4B800001, 32'h4F000000,
                                32'hCF000000, 32'h7FC00000, 32'h3F000000, 32'h00000000,
                                32'h00000001, 32'h4B000000, 32'h3F800000};
  logic [31:0] vec_r   [11] = '{32'd3, 32'hFFFFFF85, 32'h01000002, 32'h7FFFFFFF,
                                32'h80000000, 32'h80000000, 32'd0, 32'd0,
                                32'd0, 32'h00800000, 32'd1};
  logic        vec_inv [11] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
  logic        vec_inx [11] = '{1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
  int          vec_lat [11] = '{23, 18, 2, 1, 1, 1, 1, 1, 1, 1, 24};

  logic [31:0] m_r;
  logic        m_inv;
  logic        m_inx;
  int          m_lat;
  logic [31:0] rnd_f;
  logic [7:0]  rnd_exp;
  int          rnd_hold;

  fp_to_int_seq dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_float  (in_float),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Real-valued semantics: value = 1.frac * 2^e, truncated toward zero, clamped to int32.
  function automatic void model(input logic [31:0] f, output logic [31:0] r,
                                output logic inv, output logic inx, output int lat);
    int     ex;
    int     e;
    longint m;
    longint t;
    longint v;
    ex  = int'(f[30:23]);
    m   = longint'({1'b1, f[22:0]});
    inv = 1'b0;
    inx = 1'b0;
    lat = 1;
    r   = 32'd0;
    if (ex == 255) begin
      inv = 1'b1;
      r   = (f[22:0] != 23'd0 || f[31]) ? 32'h80000000 : 32'h7FFFFFFF;
    end else if (ex == 0) begin
      inx = (f[22:0] != 23'd0);
    end else begin
      e = ex - 127;
      if (e < 0) begin
        inx = 1'b1;
      end else if (e > 40) begin
        inv = 1'b1;
        r   = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
      end else begin
        t   = (e >= 23) ? (m << (e - 23)) : (m >> (23 - e));
        inx = (e < 23) && ((m & ((64'sd1 << (23 - e)) - 64'sd1)) != 64'sd0);
        v   = f[31] ? -t : t;
        if (v > 64'sd2147483647) begin
          inv = 1'b1;
          r   = 32'h7FFFFFFF;
        end else if (v < -64'sd2147483648) begin
          inv = 1'b1;
          r   = 32'h80000000;
        end else begin
          r = v[31:0];
        end
        if (e <= 30) lat = ((e >= 23) ? (e - 23) : (23 - e)) + 1;
      end
    end
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      check("valid_ready_excl", 32'(in_ready & out_valid), 32'd0);
      if (out_valid) begin
        check("valid_expected", 32'(out_valid), 32'(armed));
        check("result", result, exp_result);
        check("invalid", 32'(invalid), 32'(exp_invalid));
        check("inexact", 32'(inexact), 32'(exp_inexact));
      end
    end
  end

  task automatic convert(input logic [31:0] f, input int hold);
    logic [31:0] r;
    logic        inv;
    logic        inx;
    int          lat;
    int          n;
    model(f, r, inv, inx, lat);
    exp_result  = r;
    exp_invalid = inv;
    exp_inexact = inx;
    armed       = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_float = f;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      in_valid = 1'b0;
    end while (!out_valid && n < 40);
    check("latency", 32'(n - 1), 32'(lat));
    if (out_valid) begin
      for (int k = 0; k < hold; k++) begin
        in_float = $urandom;
        in_valid = 1'b1;
        @(negedge clock);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check("taken_out_valid", 32'(out_valid), 32'd0);
      check("taken_in_ready", 32'(in_ready), 32'd1);
    end
    armed = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_float  = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);
    check("rst_inexact", 32'(inexact), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      model(vec_f[i], m_r, m_inv, m_inx, m_lat);
      check("model_result", m_r, vec_r[i]);
      check("model_invalid", 32'(m_inv), 32'(vec_inv[i]));
      check("model_inexact", 32'(m_inx), 32'(vec_inx[i]));
      check("model_latency", 32'(m_lat), 32'(vec_lat[i]));
      convert(vec_f[i], 0);
    end

    convert(32'hC2F60000, 5);
    convert(32'h40490FDB, 0);

    // Abort a long conversion partway through the shifter.
    armed    = 1'b1;
    in_float = 32'h40490FDB;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("mid_shift_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_invalid", 32'(invalid), 32'd0);
    check("abort_inexact", 32'(inexact), 32'd0);
    reset = 1'b0;
    armed = 1'b0;
    @(negedge clock);
    check("post_abort_idle", 32'(out_valid), 32'd0);
    convert(32'h40490FDB, 0);

    for (int i = 0; i < 300; i++) begin
      rnd_exp = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(115, 160));
      rnd_f = {1'($urandom), rnd_exp, 23'($urandom)};
      if ($urandom_range(0, 7) == 0) rnd_f[22:0] = 23'd0;
      rnd_hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      convert(rnd_f, rnd_hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
